rdid_spi_reader: RTL and testbench
==================================

# rdid_spi_reader

SPI-mode-0 master that issues the JEDEC Read Identification command (0x9F) to the serial flash and captures the three returned ID bytes. It is the stage directly upstream of the LED selector: its `manufacture_id`, `memory_type` and `memory_capacity` outputs feed that block unchanged. The block also drives the flash pins `spi_cs_n`, `spi_sclk` and `spi_mosi`. A read runs once per `start` pulse, and the captured bytes are held until the next completed read.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period. Legal values are 2 to 255. SCLK frequency = f_clk / (2*CLK_DIV).
- `clk`  input  1  system clock. The block has one clock domain; all logic is on the rising edge.
- `rst_n`  input  1  reset. **Synchronous, active-low.**
- `start`  input  1  request pulse. Sampled only in IDLE; ignored while `busy`.
- `busy`  output  1  high from the cycle after an accepted `start` until the transaction ends.
- `done`  output  1  one-cycle pulse when new ID bytes are valid.
- `id_valid`  output  1  sticky. Set by the first `done`; cleared only by reset.
- `manufacture_id`  output  8  first byte returned by the flash.
- `memory_type`  output  8  second byte returned.
- `memory_capacity`  output  8  third byte returned.
- `spi_cs_n`  output  1  flash chip select, active-low.
- `spi_sclk`  output  1  SPI clock. Idles low (mode 0).
- `spi_mosi`  output  1  master data out.
- `spi_miso`  input  1  flash data in. Treated as synchronous to `clk` (the flash is clocked by this block).

## Operation
- **Reset values:**
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0.
  - `busy`=0, `done`=0, `id_valid`=0.
  - All three ID bytes = 0x00.
  - State = IDLE.
- **Divider:** a half-period counter runs 0..CLK_DIV-1. `tick` is asserted when the count equals CLK_DIV-1. The counter clears on every state change.
- **IDLE:**
  - Outputs are at their idle values (same as reset values, except the ID bytes are retained).
  - `start`=1 moves to CS_SETUP.
- **CS_SETUP:**
  - `spi_cs_n`=0, `busy`=1.
  - `spi_mosi` = bit 7 of 0x9F.
  - Lasts CLK_DIV cycles. `tick` moves to SHIFT.
- **SHIFT:**
  - Covers 32 bit periods (64 half-periods). Each `tick` toggles `spi_sclk`.
  - On a tick that drives SCLK low:
    - Shift `spi_miso` into a 32-bit shift register, MSB first. This samples at the end of the high phase.
    - Advance `spi_mosi` to the next bit.
  - MOSI carries 0x9F MSB-first for bits 0-7, then 0 for bits 8-31.
  - The 8 MISO bits captured during the command phase are discarded.
  - After the 32nd falling edge, move to CS_HOLD with `spi_sclk`=0.
- **CS_HOLD:**
  - `spi_cs_n` stays 0, `spi_sclk`=0, `spi_mosi`=0.
  - Lasts CLK_DIV cycles, then moves to GAP.
- **GAP:**
  - `spi_cs_n`=1, `busy` stays 1. Lasts CLK_DIV cycles, then returns to IDLE. This enforces the minimum CS-high time.
  - On the first GAP cycle, `done`=1 and the three ID bytes and `id_valid` update, all in that same cycle:
    - `manufacture_id` = shift[23:16]
    - `memory_type` = shift[15:8]
    - `memory_capacity` = shift[7:0]
- **ID outputs never show partial data.** They change only in the `done` cycle.
- **Boundary conditions:**
  - `start` held high continuously: a new transaction begins on the first IDLE cycle after GAP.
  - `start` while `busy`: dropped, not queued.
  - Reset mid-transaction: on the next edge, all outputs take their reset values, including clearing the ID bytes. No `done` is produced.

## Timing
- Let `start` be sampled in cycle T0.
  - `spi_cs_n` falls and `busy` rises at T0+1.
  - First SCLK rising edge at T0+1+CLK_DIV.
  - `done` and the output update at T0+1+66*CLK_DIV.
  - `busy` falls at T0+1+67*CLK_DIV.
- With CLK_DIV=4:
  - CS low for 264 cycles.
  - `done` at T0+265.
  - `busy` low at T0+269.
- MOSI changes only on the cycle SCLK falls, or at CS fall for bit 7. MOSI is stable for the entire SCLK-high phase.
- MISO is sampled at the clock edge that ends each SCLK-high phase. The flash must not change MISO before its falling SCLK edge.
- Back-to-back reads: minimum `start` spacing is 67*CLK_DIV+1 cycles.

## Test plan
- **Reset behaviour:** assert `rst_n`=0 for 3 cycles, then release.
  - Required: `spi_cs_n`=1, `spi_sclk`=0, `busy`=0, `id_valid`=0, all ID bytes 0x00.
- **Nominal read:** CLK_DIV=4, slave model returns EF 40 18.
  - `done` at T0+265.
  - `manufacture_id`=0xEF, `memory_type`=0x40, `memory_capacity`=0x18, `id_valid`=1.
  - Monitor decodes MOSI byte 0 as 0x9F.
- **Second read with new data:** slave returns 20 BA 19.
  - ID outputs hold EF/40/18 until the `done` cycle, then switch to 0x20/0xBA/0x19 in that same cycle.
- **Start while busy:** pulse `start` at T0+50 during a read.
  - Exactly one CS-low window and one `done`.
  - CS stays high for 4 cycles after the window.
- **Reset mid-SHIFT:** assert `rst_n`=0 at T0+100 with previous ID EF/40/18.
  - Next edge: `spi_cs_n`=1, `spi_sclk`=0, ID bytes 0x00, `id_valid`=0.
  - No `done` is produced.
- **CLK_DIV=2:**
  - SCLK period is 4 cycles.
  - `done` at T0+133, `busy` low at T0+135.
  - Correct capture of A5 5A C3.

Source files
------------

// File: rtl/rdid_spi_reader.sv
// rdid_spi_reader
//   SPI mode-0 master. It sends the JEDEC Read Identification command (0x9F)
//   and captures the three ID bytes the flash returns. The captured bytes
//   are held until the next read completes.
//
// Ports
//   clk, rst_n        system clock; synchronous active-low reset
//   start             request pulse, taken only while idle
//   busy              transaction in progress (CS_SETUP .. GAP)
//   done              one-cycle pulse when new ID bytes are valid
//   id_valid          sticky, set by the first done
//   manufacture_id    first returned byte
//   memory_type       second returned byte
//   memory_capacity   third returned byte
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   flash pins (sclk idles low)
//
// CLK_DIV is the number of clk cycles per SCLK half-period (2..255).
module rdid_spi_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       id_valid,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;     // half-period divider
  logic [5:0]  half_q, half_d;   // half-periods completed in SHIFT
  logic        sclk_q, sclk_d;
  logic [7:0]  tx_q, tx_d;       // MOSI bits still to send, MSB on the pin
  logic [23:0] rx_q, rx_d;       // last 24 MISO bits; command-phase bits fall off the top
  logic [7:0]  mid_q, mid_d;
  logic [7:0]  mtype_q, mtype_d;
  logic [7:0]  mcap_q, mcap_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        tick;

  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    half_d  = half_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mid_d   = mid_q;
    mtype_d = mtype_q;
    mcap_d  = mcap_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CS_SETUP;
          tx_d    = CMD_RDID;      // bit 7 appears on MOSI together with CS fall
        end
      end
      S_CS_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;          // first rising edge opens SHIFT
          half_d  = '0;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          // Falling edge: sample at the end of the high phase, then present
          // the next MOSI bit so it is stable for the whole next high phase.
          if (sclk_q) begin
            rx_d = {rx_q[22:0], spi_miso};
            tx_d = {tx_q[6:0], 1'b0};
          end
          // The 64th half-period is the low phase after the 32nd fall; its
          // tick leaves SHIFT instead of producing another rising edge.
          if (half_q == 6'd63) begin
            state_d = S_CS_HOLD;
            sclk_d  = 1'b0;
          end else begin
            sclk_d = ~sclk_q;
            half_d = half_q + 6'd1;
          end
        end
      end
      S_CS_HOLD: begin
        if (tick) begin
          state_d = S_GAP;
          done_d  = 1'b1;
          valid_d = 1'b1;
          mid_d   = rx_q[23:16];
          mtype_d = rx_q[15:8];
          mcap_d  = rx_q[7:0];
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = (state_d != state_q || tick) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      mid_q   <= '0;
      mtype_q <= '0;
      mcap_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      mid_q   <= mid_d;
      mtype_q <= mtype_d;
      mcap_q  <= mcap_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign spi_cs_n        = !(state_q == S_CS_SETUP || state_q == S_SHIFT || state_q == S_CS_HOLD);
  assign spi_sclk        = sclk_q;
  // tx_q is empty outside a transaction, so MOSI rests low without gating.
  assign spi_mosi        = tx_q[7];
  assign done            = done_q;
  assign id_valid        = valid_q;
  assign manufacture_id  = mid_q;
  assign memory_type     = mtype_q;
  assign memory_capacity = mcap_q;

endmodule

// File: tb/tb_rdid_spi_reader.sv
// Bench for rdid_spi_reader: instance 0 uses CLK_DIV=4, instance 1 uses
// CLK_DIV=2. Each instance has a flash model that shifts out a 32-bit frame
// MSB first, plus a MOSI monitor. Expected timing and ID values come from
// the transaction-level rules (T0+1+66*D, T0+1+67*D, last 24 frame bits).
module tb_rdid_spi_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, start, busy, done, id_valid, cs_n, sclk, mosi, miso;
  logic [1:0][7:0]  mid, mtype, mcap;
  logic [1:0][31:0] frame;
  logic [1:0][31:0] mon_word;
  logic [1:0][7:0]  mon_bits;
  logic [1:0]       mon_bad;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0][23:0] m_id;
  logic [1:0]       m_valid;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rdid_spi_reader #(.CLK_DIV(g == 0 ? 4 : 2)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n[g]),
      .start          (start[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .id_valid       (id_valid[g]),
      .manufacture_id (mid[g]),
      .memory_type    (mtype[g]),
      .memory_capacity(mcap[g]),
      .spi_cs_n       (cs_n[g]),
      .spi_sclk       (sclk[g]),
      .spi_mosi       (mosi[g]),
      .spi_miso       (miso[g])
    );

    // Flash model: bit n of the frame is on MISO after the n-th falling SCLK.
    int nfall = 0;
    always @(posedge cs_n[g] or negedge sclk[g]) nfall <= cs_n[g] ? 0 : nfall + 1;
    assign miso[g] = (nfall < 32) ? frame[g][5'(31 - nfall)] : 1'b0;

    // MOSI monitor: bit taken at each SCLK rise, must not move while SCLK high.
    logic [31:0] w = '0, lw = '0;
    logic [7:0]  nb = '0, lnb = '0;
    logic        bad = 1'b0, lbad = 1'b0, hold = 1'b0, sprev = 1'b0;
    always @(negedge clk) begin
      sprev <= sclk[g];
      if (cs_n[g]) begin
        if (nb != 0) begin
          lw <= w; lnb <= nb; lbad <= bad;
        end
        nb  <= '0;
        bad <= 1'b0;
      end else if (sclk[g] && !sprev) begin
        w    <= {w[30:0], mosi[g]};
        nb   <= nb + 8'd1;
        hold <= mosi[g];
      end else if (sclk[g] && mosi[g] !== hold) begin
        bad <= 1'b1;
      end
    end
    assign mon_word[g] = lw;
    assign mon_bits[g] = lnb;
    assign mon_bad[g]  = lbad;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int d);
    chk("idle_cs_n", cs_n[d], 1);
    chk("idle_sclk", sclk[d], 0);
    chk("idle_mosi", mosi[d], 0);
    chk("idle_busy", busy[d], 0);
    chk("idle_done", done[d], 0);
    chk("idle_id_valid", id_valid[d], m_valid[d]);
    chk("idle_ids", {mid[d], mtype[d], mcap[d]}, m_id[d]);
  endtask

  // One read on instance d; optional start pulse at cycle T0+pulse_k while
  // busy, or start held high to test back-to-back restart.
  task automatic do_read(input int d, input logic [23:0] id, input int pulse_k, input bit hold);
    int D, k, t_done, t_blo, t_sclk, n_done, n_fall, gap, stray;
    logic [23:0] cur;
    bit hold_ok, cs_prev;
    D = (d == 0) ? 4 : 2;
    frame[d] = {8'($urandom), id};
    cur = m_id[d];
    t_done = -1; t_blo = -1; t_sclk = -1;
    n_done = 0; n_fall = 0; gap = 0; k = 0;
    hold_ok = 1'b1; cs_prev = 1'b1;
    @(negedge clk); start[d] = 1'b1;
    @(posedge clk);                       // start sampled here: end of T0
    while (t_blo < 0 && k < 80 * D) begin
      @(negedge clk); k++;
      if (k == 1) begin
        chk("cs_fall_T1", cs_n[d], 0);
        chk("busy_rise_T1", busy[d], 1);
        if (!hold) start[d] = 1'b0;
      end
      if (pulse_k > 0 && k == pulse_k) start[d] = 1'b1;
      if (pulse_k > 0 && k == pulse_k + 1) start[d] = 1'b0;
      if (sclk[d] && t_sclk < 0) t_sclk = k;
      if (cs_prev && !cs_n[d]) n_fall++;
      cs_prev = cs_n[d];
      if (cs_n[d] && busy[d]) gap++;
      if (done[d]) begin
        n_done++;
        if (t_done < 0) t_done = k;
        cur = id;
      end
      if ({mid[d], mtype[d], mcap[d]} !== cur) hold_ok = 1'b0;
      if (!busy[d]) t_blo = k;
    end
    chk("done_time", t_done, 1 + 66 * D);
    chk("busy_fall_time", t_blo, 1 + 67 * D);
    chk("first_sclk_rise", t_sclk, 1 + D);
    chk("done_count", n_done, 1);
    chk("cs_windows", n_fall, 1);
    chk("cs_high_gap", gap, D);
    chk("ids_no_partial", hold_ok, 1);
    chk("ids", {mid[d], mtype[d], mcap[d]}, id);
    chk("id_valid", id_valid[d], 1);
    chk("mosi_word", mon_word[d], 32'h9F00_0000);
    chk("mosi_bits", mon_bits[d], 32);
    chk("mosi_stable_high", mon_bad[d], 0);
    m_id[d] = id;
    m_valid[d] = 1'b1;
    if (hold) begin
      @(negedge clk);
      chk("held_start_restart", busy[d], 1);
      start[d] = 1'b0;
      k = 0; n_done = 0;
      while (busy[d] && k < 80 * D) begin
        @(negedge clk); k++;
        if (done[d]) n_done++;
      end
      chk("held_second_done", n_done, 1);
      chk("held_second_len", k, 67 * D);
      chk("held_second_ids", {mid[d], mtype[d], mcap[d]}, id);
    end else begin
      stray = 0;
      repeat (2 * D) begin
        @(negedge clk);
        if (!cs_n[d] || busy[d]) stray++;
      end
      chk("start_not_queued", stray, 0);
    end
  endtask

  task automatic do_reset_mid(input int d, input logic [23:0] id, input int rk);
    int D, n_done, n_cs;
    D = (d == 0) ? 4 : 2;
    frame[d] = {8'($urandom), id};
    @(negedge clk); start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk); start[d] = 1'b0;      // cycle T0+1
    repeat (rk - 1) @(negedge clk);       // cycle T0+rk
    chk("rst_mid_in_window", cs_n[d], 0);
    rst_n[d] = 1'b0;
    @(negedge clk);
    m_id[d] = '0;
    m_valid[d] = 1'b0;
    chk("rst_mid_cs_n", cs_n[d], 1);
    chk("rst_mid_sclk", sclk[d], 0);
    chk("rst_mid_busy", busy[d], 0);
    chk("rst_mid_ids", {mid[d], mtype[d], mcap[d]}, 24'h0);
    chk("rst_mid_id_valid", id_valid[d], 0);
    chk("rst_mid_done", done[d], 0);
    @(negedge clk); rst_n[d] = 1'b1;
    n_done = 0; n_cs = 0;
    repeat (70 * D) begin
      @(negedge clk);
      if (done[d]) n_done++;
      if (!cs_n[d]) n_cs++;
    end
    chk("rst_mid_no_done", n_done, 0);
    chk("rst_mid_no_restart", n_cs, 0);
  endtask

  initial begin
    rst_n = '0; start = '0; frame = '0;
    m_id = '0; m_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    do_read(0, 24'hEF4018, 0, 1'b0);
    do_read(0, 24'h20BA19, 50, 1'b0);
    repeat (3) do_read(0, 24'($urandom), int'($urandom_range(2, 240)), 1'b0);
    do_read(0, 24'($urandom), 0, 1'b1);
    do_read(0, 24'hEF4018, 0, 1'b0);
    do_reset_mid(0, 24'h123456, 100);
    check_idle(0);
    do_read(0, 24'($urandom), 0, 1'b0);

    do_read(1, 24'hA55AC3, 0, 1'b0);
    repeat (2) do_read(1, 24'($urandom), int'($urandom_range(2, 120)), 1'b0);
    check_idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
